// File: rtl/io_pad_mux_ctrl.sv
// io_pad_mux_ctrl
//   Shares the user GPIO pads among NUM_FUNC on-chip requester functions.
//   Each pad has a 2-bit function select configured over Wishbone. A select
//   change is never applied directly: the changing pads are first isolated
//   (forced to tristate), held there for GUARD_CYCLES, and only then committed
//   to the new function. No pad is ever driven by two functions, and no pad
//   glitches from one function to another.
//
// Ports
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   wbs_*                Wishbone slave (single-cycle ack, registered read data)
//   func_out, func_oeb   per-function pad values, function f at [f*NUM_IO +: NUM_IO]
//   io_out, io_oeb       registered pad drive (io_oeb = 1 means tristate)
//   busy                 a change sequence is in progress
//
// Register map (word offset adr[7:2])
//   0 SEL0 pads 0-15, 1 SEL1 pads 16-31, 2 SEL2 pads 32-37 in [11:0]
//   3 STATUS (RO): [0] busy, [2:1] FSM state code
module io_pad_mux_ctrl #(
  parameter int NUM_IO       = 38,
  parameter int NUM_FUNC     = 4,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_we_i,
  input  logic [3:0]                 wbs_sel_i,
  input  logic [31:0]                wbs_adr_i,
  input  logic [31:0]                wbs_dat_i,
  output logic [31:0]                wbs_dat_o,
  output logic                       wbs_ack_o,
  input  logic [NUM_FUNC*NUM_IO-1:0] func_out,
  input  logic [NUM_FUNC*NUM_IO-1:0] func_oeb,
  output logic [NUM_IO-1:0]          io_out,
  output logic [NUM_IO-1:0]          io_oeb,
  output logic                       busy
);

  localparam int SEL_W = 2 * NUM_IO;
  localparam int CNT_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISOLATE = 2'd1,
    ST_GUARD   = 2'd2,
    ST_COMMIT  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [SEL_W-1:0]  cur_sel, cur_sel_nxt;
  logic [SEL_W-1:0]  tgt_sel, tgt_sel_nxt;
  logic [SEL_W-1:0]  snap_sel, snap_sel_nxt;
  logic [NUM_IO-1:0] mask, mask_nxt;
  logic [NUM_IO-1:0] diff;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  logic              wb_req;
  logic              wb_wr;
  logic [5:0]        wb_word;
  logic [95:0]       sel_ext;
  logic [31:0]       rd_data;

  logic [NUM_FUNC-1:0][NUM_IO-1:0] func_out_v;
  logic [NUM_FUNC-1:0][NUM_IO-1:0] func_oeb_v;
  logic [NUM_IO-1:0]               pad_out_nxt;
  logic [NUM_IO-1:0]               pad_oeb_nxt;

  assign func_out_v = func_out;
  assign func_oeb_v = func_oeb;

  // Holding off a new request while ack is high gives the 2-cycle transfer.
  assign wb_req  = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wb_wr   = wb_req & wbs_we_i;
  assign wb_word = wbs_adr_i[7:2];
  assign busy    = (state != ST_IDLE);

  // Select fields beyond the last pad read as zero.
  assign sel_ext = 96'(tgt_sel);

  always_comb begin
    rd_data = '0;
    case (wb_word)
      6'd0:    rd_data = sel_ext[31:0];
      6'd1:    rd_data = sel_ext[63:32];
      6'd2:    rd_data = sel_ext[95:64];
      6'd3:    rd_data = {29'd0, state, busy};
      default: rd_data = '0;
    endcase
  end

  // Byte-lane write into the target selects; bits past the last pad have no
  // storage, so writes to them vanish.
  always_comb begin
    tgt_sel_nxt = tgt_sel;
    if (wb_wr) begin
      for (int i = 0; i < SEL_W; i++) begin
        if (wb_word == 6'(i / 32) && wbs_sel_i[(i % 32) / 8])
          tgt_sel_nxt[i] = wbs_dat_i[i % 32];
      end
    end
  end

  always_comb begin
    diff = '0;
    for (int n = 0; n < NUM_IO; n++)
      diff[n] = (tgt_sel[2*n +: 2] != cur_sel[2*n +: 2]);
  end

  always_comb begin
    state_nxt    = state;
    cur_sel_nxt  = cur_sel;
    snap_sel_nxt = snap_sel;
    mask_nxt     = mask;
    cnt_nxt      = cnt;
    case (state)
      ST_IDLE: begin
        // The snapshot freezes the sequence target; later writes only
        // touch tgt_sel and are picked up by the next sequence.
        if (|diff) begin
          mask_nxt     = diff;
          snap_sel_nxt = tgt_sel;
          state_nxt    = ST_ISOLATE;
        end
      end
      ST_ISOLATE: begin
        cnt_nxt   = CNT_W'(GUARD_CYCLES - 1);
        state_nxt = ST_GUARD;
      end
      ST_GUARD: begin
        if (cnt == '0) state_nxt = ST_COMMIT;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      ST_COMMIT: begin
        for (int n = 0; n < NUM_IO; n++)
          if (mask[n]) cur_sel_nxt[2*n +: 2] = snap_sel[2*n +: 2];
        mask_nxt  = '0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pad_out_nxt = '0;
    pad_oeb_nxt = '1;
    for (int n = 0; n < NUM_IO; n++) begin
      if (!mask[n]) begin
        pad_out_nxt[n] = func_out_v[cur_sel[2*n +: 2]][n];
        pad_oeb_nxt[n] = func_oeb_v[cur_sel[2*n +: 2]][n];
      end
    end
  end

  // ---- Bus response stage: ack and read data one cycle after the request
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= wb_req;
      wbs_dat_o <= (wb_req && !wbs_we_i) ? rd_data : '0;
    end
  end

  // ---- Sequencer state
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      cur_sel  <= '0;
      tgt_sel  <= '0;
      snap_sel <= '0;
      mask     <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      cur_sel  <= cur_sel_nxt;
      tgt_sel  <= tgt_sel_nxt;
      snap_sel <= snap_sel_nxt;
      mask     <= mask_nxt;
      cnt      <= cnt_nxt;
    end
  end

  // ---- Pad output stage
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      io_out <= '0;
      io_oeb <= '1;
    end else begin
      io_out <= pad_out_nxt;
      io_oeb <= pad_oeb_nxt;
    end
  end

endmodule

// File: tb/tb_io_pad_mux_ctrl.sv
module tb_io_pad_mux_ctrl;

  localparam int NUM_IO = 38;
  localparam int NUM_FUNC = 4;

  localparam logic [37:0] F0_OUT = 38'h15_5555_5555;
  localparam logic [37:0] F1_OUT = 38'h3F_FFFF_FFFF;
  localparam logic [37:0] F2_OUT = 38'h3F_FFFF_FFFF;
  localparam logic [37:0] F3_OUT = 38'h0F_0F0F_0F0F;
  localparam logic [37:0] F0_OEB = 38'h00_0000_0000;
  localparam logic [37:0] F1_OEB = 38'h00_0000_0000;
  localparam logic [37:0] F2_OEB = 38'h3F_FFFF_FFFF;
  localparam logic [37:0] F3_OEB = 38'h00_0000_0000;

  logic        clk;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic [31:0] rdat;
  logic        ack;
  logic [NUM_FUNC*NUM_IO-1:0] func_out, func_oeb;
  logic [NUM_IO-1:0] io_out, io_oeb;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  io_pad_mux_ctrl #(.NUM_IO(NUM_IO), .NUM_FUNC(NUM_FUNC), .GUARD_CYCLES(4)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_dat_o(rdat),
    .wbs_ack_o(ack),
    .func_out (func_out),
    .func_oeb (func_oeb),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the ack edge, with ack low again.
  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d; sel = s;
    tick();
    chk("wr_ack", 64'(ack), 64'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
    tick();
    chk("rd_ack", 64'(ack), 64'd1);
    d = rdat;
    cyc = 1'b0; stb = 1'b0;
    tick();
    chk("rd_ack_low", 64'(ack), 64'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [31:0] d;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0;
    func_out = {F3_OUT, F2_OUT, F1_OUT, F0_OUT};
    func_oeb = {F3_OEB, F2_OEB, F1_OEB, F0_OEB};

    // Reset state
    tick(); tick();
    chk("rst_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    chk("rst_out", 64'(io_out), 64'h0);
    chk("rst_ack", 64'(ack), 64'h0);
    chk("rst_dat", 64'(rdat), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    rst = 1'b0;
    tick();
    chk("f0_out", 64'(io_out), 64'h15_5555_5555);
    chk("f0_oeb", 64'(io_oeb), 64'h0);

    // Pad1 -> func1: 6 cycles isolated, then follows func1
    wb_write(32'h0, 32'h4, 4'hF);
    chk("seq_busy", 64'(busy), 64'd1);
    chk("seq_k1_oeb", 64'(io_oeb), 64'h0);
    for (int k = 2; k <= 7; k++) begin
      tick();
      chk("seq_iso_oeb", 64'(io_oeb), 64'h2);
      chk("seq_iso_out", 64'(io_out), 64'h15_5555_5555);
    end
    tick();
    chk("seq_new_out", 64'(io_out), 64'h15_5555_5557);
    chk("seq_new_oeb", 64'(io_oeb), 64'h0);
    chk("seq_done", 64'(busy), 64'd0);

    // Readback and a write equal to cur_sel
    wb_read(32'h0, d);
    chk("rd_sel0", 64'(d), 64'h4);
    wb_write(32'h0, 32'h4, 4'hF);
    tick();
    chk("same_sel_busy", 64'(busy), 64'd0);

    // STATUS during GUARD (pad1 back to func0)
    wb_write(32'h0, 32'h0, 4'hF);
    tick();
    wb_read(32'hC, d);
    chk("status_guard", 64'(d), 64'h5);
    wait_idle();
    tick();
    chk("revert_out", 64'(io_out), 64'h15_5555_5555);

    // Unmapped offset
    wb_read(32'h14, d);
    chk("rd_off5", 64'(d), 64'h0);
    wb_write(32'h14, 32'hFFFF_FFFF, 4'hF);
    tick();
    chk("wr_off5_busy", 64'(busy), 64'd0);
    wb_read(32'h0, d);
    chk("wr_off5_sel0", 64'(d), 64'h0);

    // Byte lane 1 of SEL1 -> pads 20-23 to func3
    wb_write(32'h4, 32'hFFFF_FFFF, 4'b0010);
    tick();
    chk("lane_oeb", 64'(io_oeb), 64'h00_00F0_0000);
    chk("lane_out", 64'(io_out), 64'h15_5505_5555);
    wait_idle();
    tick();
    chk("lane_new_oeb", 64'(io_oeb), 64'h0);
    chk("lane_new_out", 64'(io_out), 64'h15_5505_5555);
    wb_read(32'h4, d);
    chk("rd_sel1", 64'(d), 64'h0000_FF00);

    // Write during GUARD: commit func1, one idle cycle, then func2
    wb_write(32'h0, 32'h4, 4'hF);
    tick();
    wb_write(32'h0, 32'h8, 4'hF);
    tick(); tick(); tick();
    chk("mid_idle_busy", 64'(busy), 64'd0);
    tick();
    chk("mid_restart_busy", 64'(busy), 64'd1);
    chk("mid_f1_out", 64'(io_out), 64'h15_5505_5557);
    chk("mid_f1_oeb", 64'(io_oeb), 64'h0);
    wait_idle();
    tick();
    chk("mid_f2_out", 64'(io_out), 64'h15_5505_5557);
    chk("mid_f2_oeb", 64'(io_oeb), 64'h2);
    wb_read(32'h0, d);
    chk("rd_sel0_f2", 64'(d), 64'h8);

    // SEL2: upper bits read zero, pads 32-37 to func3
    wb_write(32'h8, 32'hFFFF_FFFF, 4'hF);
    wb_read(32'h8, d);
    chk("rd_sel2", 64'(d), 64'h0000_0FFF);
    wait_idle();
    tick();
    chk("sel2_out", 64'(io_out), 64'h0F_5505_5557);
    chk("sel2_oeb", 64'(io_oeb), 64'h2);

    // Reset during GUARD aborts the sequence
    wb_write(32'h0, 32'hC, 4'hF);
    tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
    chk("abort_out", 64'(io_out), 64'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_out", 64'(io_out), 64'h15_5555_5555);
    chk("post_rst_oeb", 64'(io_oeb), 64'h0);
    tick(); tick();
    chk("post_rst_busy", 64'(busy), 64'd0);
    wb_read(32'h0, d);
    chk("post_rst_sel0", 64'(d), 64'h0);
    wb_read(32'h4, d);
    chk("post_rst_sel1", 64'(d), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
